pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Producer side of the pipeline control registers: generates the stall, flush and clear signals that the Decode/Execute, Execute/Memory and Memory/WriteBack control registers consume, plus operand-forwarding selects for Execute.
- Keeps an internal scoreboard of the register addresses of in-flight instructions and handles load-use, taken branch/jump and multi-cycle data-memory waits.
- The memory wait is tracked by a state machine with timeout. A saturating stall-cycle counter is provided for performance monitoring.

Parameters:
- MEM_TIMEOUT, 16: stalled memory cycles tolerated before the ERROR state; legal range ≥1.
- CNT_W, 32: width of the stall-cycle counter.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- valid_D  in  1  Decode holds a real instruction
- rs1_D  in  5  Decode source register 1
- rs2_D  in  5  Decode source register 2
- rd_D  in  5  Decode destination register
- regWrite_D  in  1  Decode instruction writes the register file
- isLoad_D  in  1  Decode instruction is a load (wdSrc selects memory)
- pcSrc_E  in  1  taken branch or jump resolved in Execute
- mem_req_M  in  1  Memory stage issues a data access
- mem_ready  in  1  data memory completes the access this cycle
- stall_F  out  1  hold PC
- stall_D  out  1  hold Fetch/Decode register
- stall_E  out  1  hold Decode/Execute register
- stall_M  out  1  hold Execute/Memory register
- flush_D  out  1  clear Fetch/Decode register
- flush_E  out  1  clr of Decode/Execute control register
- flush_W  out  1  insert bubble into Memory/WriteBack register
- forwardA_E  out  2  operand A source: 00 register file, 01 WriteBack result, 10 Memory ALU result
- forwardB_E  out  2  operand B source, same encoding as forwardA_E
- mem_error  out  1  memory timeout; sticky until reset
- stall_cnt  out  CNT_W  count of cycles with stall_F=1, saturating at all-ones

Behaviour:
- Reset:
  - The scoreboard clears every field to 0.
  - The FSM goes to IDLE; the wait counter, stall_cnt and mem_error go to 0.
  - While reset=1, every stall and flush output is 0 and both forward selects are 00.
- Scoreboard:
  - Execute entry: rd_E, rs1_E, rs2_E, regWrite_E, isLoad_E.
  - Memory entry: rd_M, regWrite_M, isLoad_M.
  - WriteBack entry: rd_W, regWrite_W.
  - Decode fields are qualified by valid_D: when valid_D=0, regWrite and isLoad are treated as 0.
- memStall (combinational):
  - (IDLE & mem_req_M & ~mem_ready), or
  - (WAIT & ~mem_ready), or
  - ERROR.
- loadUse: valid_D & isLoad_E & regWrite_E & rd_E≠0 & (rd_E==rs1_D | rd_E==rs2_D).
- Output priority, highest first:
  1. memStall: stall_F=stall_D=stall_E=stall_M=1, flush_W=1, all other flushes 0.
  2. pcSrc_E: flush_D=flush_E=1, no stalls. Branch wins over a simultaneous loadUse.
  3. loadUse: stall_F=stall_D=1, flush_E=1.
  4. Otherwise all stall and flush outputs are 0.
- Scoreboard update each cycle (reset has priority):
  - memStall: Execute and Memory entries hold; the WriteBack entry clears.
  - Otherwise:
    - Execute entry loads the Decode fields, or zeros when flush_E=1.
    - Memory entry loads from the Execute entry.
    - WriteBack entry loads from the Memory entry.
- Forwarding (combinational, per operand; operand A uses rs1_E, operand B uses rs2_E):
  - 10 when regWrite_M & ~isLoad_M & rd_M≠0 & rd_M==rs_E.
  - Else 01 when regWrite_W & rd_W≠0 & rd_W==rs_E.
  - Else 00.
  - Memory-stage match has priority over WriteBack-stage match.
  - x0 never forwards.
- FSM:
  - IDLE:
    - mem_req_M & ~mem_ready: go to WAIT, counter←1.
    - mem_req_M & mem_ready in the same cycle: no stall, stay in IDLE.
  - WAIT:
    - mem_ready: go to IDLE. No stall in that cycle; the pipeline advances.
    - else counter==MEM_TIMEOUT: go to ERROR.
    - else counter←counter+1.
  - ERROR: full freeze, mem_error=1. Exits only on reset.
  - Reset in any state returns the FSM to IDLE and clears mem_error on the next edge.
- stall_cnt: increments on every cycle with stall_F=1 and holds at all-ones.

Decomposition:
- Package pipeline_hazard_pkg:
  - forward_sel_t enum: FWD_RF=2'b00, FWD_W=2'b01, FWD_M=2'b10.
  - hazard_state_t enum: IDLE, WAIT, ERROR.
  - Scoreboard entry struct.
- Sub-module hazard_mem_wait_fsm: contains the FSM, the wait counter and mem_error, and outputs memStall.

Test Plan:
1. Write of x5 in Memory stage (ALU), rs1_E=5 → forwardA_E=10. Next cycle, with x5 in WriteBack and rs2_E=5 → forwardB_E=01. With rd=0 matching → both selects 00.
2. Load into x7 in Execute, valid_D=1, rs2_D=7 → exactly 1 cycle of stall_F=stall_D=flush_E=1. Next cycle forwardB_E=01. stall_cnt=1.
3. Same load-use condition plus pcSrc_E=1 in the same cycle → flush_D=flush_E=1, stall_F=0, stall_cnt unchanged.
4. mem_req_M=1 with mem_ready low for 3 cycles then high → 3 cycles of stall_F..stall_M=flush_W=1. FSM goes IDLE→WAIT→IDLE. No stall in the ready cycle. The Execute entry and forward selects hold across the wait.
5. MEM_TIMEOUT=4, mem_ready held low → ERROR entered after 5 stalled cycles, mem_error=1 and sticky. Asserting reset → mem_error=0 and FSM in IDLE after the next edge.
6. CNT_W=4 with 20 load-use stalls → stall_cnt saturates at 15.

Source files
------------

// File: rtl/pipeline_hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// memory-wait FSM states, scoreboard entries and the forwarding rule.
package pipeline_hazard_pkg;

  localparam int unsigned REG_W = 5;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } forward_sel_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    ERROR = 2'd2
  } hazard_state_t;

  // Destination info tracked for every in-flight stage.
  typedef struct packed {
    logic [REG_W-1:0] rd;
    logic             reg_write;
    logic             is_load;
  } sb_entry_t;

  // Execute stage additionally keeps its source registers for forwarding.
  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    sb_entry_t        dst;
  } exec_entry_t;

  // Memory-stage ALU result wins over WriteBack; loads in Memory have no
  // data yet, and x0 is never forwarded.
  function automatic forward_sel_t fwd_sel(input logic [REG_W-1:0] rs,
                                           input sb_entry_t        m,
                                           input logic [REG_W-1:0] rd_w,
                                           input logic             wr_w);
    forward_sel_t sel;
    sel = FWD_RF;
    if (m.reg_write && !m.is_load && (m.rd != '0) && (m.rd == rs)) begin
      sel = FWD_M;
    end else if (wr_w && (rd_w != '0) && (rd_w == rs)) begin
      sel = FWD_W;
    end
    return sel;
  endfunction

endpackage

// File: rtl/hazard_mem_wait_fsm.sv
// Tracks multi-cycle data-memory accesses with a timeout.
// Ports: clk, reset (sync, active-high), mem_req_M / mem_ready from the
// Memory stage; mem_stall_c (combinational freeze request), mem_error
// (registered, sticky until reset).
module hazard_mem_wait_fsm
  import pipeline_hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic mem_req_M,
  input  logic mem_ready,
  output logic mem_stall_c,
  output logic mem_error
);

  localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

  hazard_state_t     state, state_nx;
  logic [WCNT_W-1:0] wcnt, wcnt_nx;

  // State, wait counter and error flag registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      wcnt      <= '0;
      mem_error <= 1'b0;
    end else begin
      state     <= state_nx;
      wcnt      <= wcnt_nx;
      mem_error <= (state_nx == ERROR);
    end
  end

  // Next state and stall request; the ready cycle itself never stalls.
  always_comb begin
    state_nx    = state;
    wcnt_nx     = wcnt;
    mem_stall_c = 1'b0;
    unique case (state)
      IDLE: begin
        if (mem_req_M && !mem_ready) begin
          mem_stall_c = 1'b1;
          state_nx    = WAIT;
          wcnt_nx     = WCNT_W'(1);
        end
      end
      WAIT: begin
        if (mem_ready) begin
          state_nx = IDLE;
          wcnt_nx  = '0;
        end else begin
          mem_stall_c = 1'b1;
          if (wcnt == WCNT_W'(MEM_TIMEOUT)) begin
            state_nx = ERROR;
          end else begin
            wcnt_nx = wcnt + WCNT_W'(1);
          end
        end
      end
      ERROR: begin
        mem_stall_c = 1'b1;
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller: drives stall/flush controls for the pipeline registers
// and Execute operand-forwarding selects from an internal scoreboard of
// in-flight destination registers.
// Ports: Decode instruction fields (valid_D, rs1_D, rs2_D, rd_D, regWrite_D,
// isLoad_D), pcSrc_E, mem_req_M, mem_ready; outputs stall_F/D/E/M,
// flush_D/E/W, forwardA_E/forwardB_E, mem_error, stall_cnt.
module pipeline_hazard_ctrl
  import pipeline_hazard_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_D,
  input  logic [REG_W-1:0] rs1_D,
  input  logic [REG_W-1:0] rs2_D,
  input  logic [REG_W-1:0] rd_D,
  input  logic             regWrite_D,
  input  logic             isLoad_D,
  input  logic             pcSrc_E,
  input  logic             mem_req_M,
  input  logic             mem_ready,
  output logic             stall_F,
  output logic             stall_D,
  output logic             stall_E,
  output logic             stall_M,
  output logic             flush_D,
  output logic             flush_E,
  output logic             flush_W,
  output logic [1:0]       forwardA_E,
  output logic [1:0]       forwardB_E,
  output logic             mem_error,
  output logic [CNT_W-1:0] stall_cnt
);

  logic             mem_stall_c;
  logic             load_use_c;
  exec_entry_t      dec_entry_c;
  exec_entry_t      sb_e;
  sb_entry_t        sb_m;
  logic [REG_W-1:0] rd_w;
  logic             reg_write_w;

  hazard_mem_wait_fsm #(
    .MEM_TIMEOUT(MEM_TIMEOUT)
  ) u_mem_wait (
    .clk        (clk),
    .reset      (reset),
    .mem_req_M  (mem_req_M),
    .mem_ready  (mem_ready),
    .mem_stall_c(mem_stall_c),
    .mem_error  (mem_error)
  );

  // Decode fields as they would enter Execute; bubbles never write.
  always_comb begin
    dec_entry_c               = '0;
    dec_entry_c.rs1           = rs1_D;
    dec_entry_c.rs2           = rs2_D;
    dec_entry_c.dst.rd        = rd_D;
    dec_entry_c.dst.reg_write = valid_D & regWrite_D;
    dec_entry_c.dst.is_load   = valid_D & isLoad_D;
  end

  assign load_use_c = valid_D & sb_e.dst.is_load & sb_e.dst.reg_write &
                      (sb_e.dst.rd != '0) &
                      ((sb_e.dst.rd == rs1_D) | (sb_e.dst.rd == rs2_D));

  // Prioritised stall/flush controls, all quiet during reset.
  always_comb begin
    stall_F = 1'b0;
    stall_D = 1'b0;
    stall_E = 1'b0;
    stall_M = 1'b0;
    flush_D = 1'b0;
    flush_E = 1'b0;
    flush_W = 1'b0;
    if (!reset) begin
      if (mem_stall_c) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        stall_E = 1'b1;
        stall_M = 1'b1;
        flush_W = 1'b1;
      end else if (pcSrc_E) begin
        flush_D = 1'b1;
        flush_E = 1'b1;
      end else if (load_use_c) begin
        stall_F = 1'b1;
        stall_D = 1'b1;
        flush_E = 1'b1;
      end
    end
  end

  assign forwardA_E = reset ? 2'(FWD_RF) : 2'(fwd_sel(sb_e.rs1, sb_m, rd_w, reg_write_w));
  assign forwardB_E = reset ? 2'(FWD_RF) : 2'(fwd_sel(sb_e.rs2, sb_m, rd_w, reg_write_w));

  // Scoreboard mirrors the pipeline; a memory freeze holds E/M and bubbles W.
  always_ff @(posedge clk) begin
    if (reset) begin
      sb_e        <= '0;
      sb_m        <= '0;
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else if (mem_stall_c) begin
      rd_w        <= '0;
      reg_write_w <= 1'b0;
    end else begin
      sb_e        <= flush_E ? '0 : dec_entry_c;
      sb_m        <= sb_e.dst;
      rd_w        <= sb_m.rd;
      reg_write_w <= sb_m.reg_write;
    end
  end

  // Saturating count of front-end stall cycles.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
    end else if (stall_F && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
`timescale 1ns/1ps
module tb_pipeline_hazard_ctrl;

  localparam int unsigned TO = 4;
  localparam int unsigned CW = 4;
  localparam int CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          valid_D;
  logic [4:0]    rs1_D, rs2_D, rd_D;
  logic          regWrite_D, isLoad_D, pcSrc_E, mem_req_M, mem_ready;
  logic          stall_F, stall_D, stall_E, stall_M;
  logic          flush_D, flush_E, flush_W;
  logic [1:0]    forwardA_E, forwardB_E;
  logic          mem_error;
  logic [CW-1:0] stall_cnt;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .valid_D(valid_D), .rs1_D(rs1_D), .rs2_D(rs2_D),
    .rd_D(rd_D), .regWrite_D(regWrite_D), .isLoad_D(isLoad_D), .pcSrc_E(pcSrc_E),
    .mem_req_M(mem_req_M), .mem_ready(mem_ready), .stall_F(stall_F), .stall_D(stall_D),
    .stall_E(stall_E), .stall_M(stall_M), .flush_D(flush_D), .flush_E(flush_E),
    .flush_W(flush_W), .forwardA_E(forwardA_E), .forwardB_E(forwardB_E),
    .mem_error(mem_error), .stall_cnt(stall_cnt)
  );

  // ---------------- stimulus record ----------------
  typedef struct packed {
    logic       rst;
    logic       v;
    logic [4:0] rs1, rs2, rd;
    logic       wr, ld, pc, req, rdy;
  } stim_t;

  function automatic stim_t ins(logic v, int rs1, int rs2, int rd, logic wr, logic ld);
    stim_t s;
    s = '0;
    s.v = v; s.rs1 = 5'(rs1); s.rs2 = 5'(rs2); s.rd = 5'(rd); s.wr = wr; s.ld = ld;
    s.rdy = 1'b1;
    return s;
  endfunction

  task automatic drive(stim_t s);
    reset = s.rst; valid_D = s.v; rs1_D = s.rs1; rs2_D = s.rs2; rd_D = s.rd;
    regWrite_D = s.wr; isLoad_D = s.ld; pcSrc_E = s.pc; mem_req_M = s.req; mem_ready = s.rdy;
    #2;
  endtask

  // ---------------- reference model ----------------
  // Instructions in flight as plain records; memory wait tracked as the
  // number of consecutive stalled cycles of the current access.
  typedef struct {
    int rd; int rs1; int rs2; bit wr; bit ld;
  } instr_t;

  instr_t pe, pm, pw, zi;
  int waited = 0;
  bit err = 0;
  int scnt = 0;

  function automatic bit model_mem_stall();
    return err || (!mem_ready && ((waited > 0) || mem_req_M));
  endfunction

  function automatic logic [1:0] model_fwd(int rs);
    if (pm.wr && !pm.ld && pm.rd != 0 && pm.rd == rs) return 2'b10;
    if (pw.wr && pw.rd != 0 && pw.rd == rs) return 2'b01;
    return 2'b00;
  endfunction

  // {stall_F,stall_D,stall_E,stall_M,flush_D,flush_E,flush_W,fA,fB,mem_error,stall_cnt}
  function automatic logic [15:0] model_expect();
    logic [6:0] sf;
    logic [1:0] fa, fb;
    bit lu;
    lu = valid_D && pe.ld && pe.wr && pe.rd != 0 && (pe.rd == int'(rs1_D) || pe.rd == int'(rs2_D));
    sf = 7'b0;
    fa = 2'b00;
    fb = 2'b00;
    if (!reset) begin
      if (model_mem_stall()) sf = 7'b1111001;
      else if (pcSrc_E)      sf = 7'b0000110;
      else if (lu)           sf = 7'b1100010;
      fa = model_fwd(pe.rs1);
      fb = model_fwd(pe.rs2);
    end
    return {sf, fa, fb, err, 4'(scnt)};
  endfunction

  function automatic logic [15:0] act_vec();
    return {stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
            forwardA_E, forwardB_E, mem_error, stall_cnt};
  endfunction

  // Advance model and DUT by one clock.
  task automatic tick();
    logic [15:0] e;
    bit ms;
    instr_t d;
    e  = model_expect();
    ms = model_mem_stall();
    d.rd = int'(rd_D); d.rs1 = int'(rs1_D); d.rs2 = int'(rs2_D);
    d.wr = valid_D && regWrite_D; d.ld = valid_D && isLoad_D;
    if (reset) begin
      pe = zi; pm = zi; pw = zi; waited = 0; err = 0; scnt = 0;
    end else begin
      if (e[15] && scnt < CNT_MAX) scnt++;
      if (ms) begin
        pw = zi;
        if (!err) begin
          waited++;
          if (waited > int'(TO)) err = 1;
        end
      end else begin
        waited = 0;
        pw = pm;
        pm = pe;
        pe = e[10] ? zi : d;
      end
    end
    @(posedge clk);
    #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    stim_t s;
    s = ins(1, 3, 4, 3, 1, 1);
    s.rst = 1; s.pc = 1; s.req = 1; s.rdy = 0;
    drive(s);
    tick();
    drive(s);
    vectors++;
    if (act_vec() !== 16'h0 || act_vec() !== model_expect()) begin
      miscompares++;
      $display("FAIL reset_hold: got %h expected %h", act_vec(), 16'h0);
    end
    tick();
    drive(ins(0, 0, 0, 0, 0, 0));
    vectors++;
    if (act_vec() !== model_expect()) begin
      miscompares++;
      $display("FAIL reset_release: got %h expected %h", act_vec(), model_expect());
    end
    tick();
  endtask

  task automatic test_forwarding();
    stim_t rows[6];
    rows[0] = ins(1, 0, 0, 5, 1, 0);
    rows[1] = ins(1, 5, 1, 6, 1, 0);
    rows[2] = ins(1, 2, 5, 7, 1, 0);
    rows[3] = ins(1, 0, 0, 0, 1, 0);
    rows[4] = ins(1, 0, 0, 0, 0, 0);
    rows[5] = ins(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      drive(rows[i]);
      vectors++;
      if (act_vec() !== model_expect()) begin
        miscompares++;
        $display("FAIL fwd row %0d: got %h expected %h", i, act_vec(), model_expect());
      end
      if (i == 2) begin
        vectors++;
        if (forwardA_E !== 2'b10) begin
          miscompares++;
          $display("FAIL fwd_mem_A: got %b expected 10", forwardA_E);
        end
      end
      if (i == 3) begin
        vectors++;
        if (forwardB_E !== 2'b01) begin
          miscompares++;
          $display("FAIL fwd_wb_B: got %b expected 01", forwardB_E);
        end
      end
      if (i == 5) begin
        vectors++;
        if ({forwardA_E, forwardB_E} !== 4'b0000) begin
          miscompares++;
          $display("FAIL fwd_x0: got %b%b expected 0000", forwardA_E, forwardB_E);
        end
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    stim_t rows[4];
    rows[0] = ins(1, 0, 0, 7, 1, 1);
    rows[1] = ins(1, 3, 7, 8, 1, 0);
    rows[2] = rows[1];
    rows[3] = ins(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      drive(rows[i]);
      vectors++;
      if (act_vec() !== model_expect()) begin
        miscompares++;
        $display("FAIL load_use row %0d: got %h expected %h", i, act_vec(), model_expect());
      end
      vectors++;
      if (i == 1 && {stall_F, stall_D, flush_E, flush_D} !== 4'b1110) begin
        miscompares++;
        $display("FAIL load_use_stall: got %b expected 1110", {stall_F, stall_D, flush_E, flush_D});
      end else if (i == 2 && {stall_F, stall_cnt} !== {1'b0, 4'd1}) begin
        miscompares++;
        $display("FAIL load_use_once: got %b/%0d expected 0/1", stall_F, stall_cnt);
      end else if (i == 3 && forwardB_E !== 2'b01) begin
        miscompares++;
        $display("FAIL load_use_fwd: got %b expected 01", forwardB_E);
      end
      tick();
    end
  endtask

  task automatic test_branch_over_load_use();
    stim_t rows[3];
    rows[0] = ins(1, 0, 0, 9, 1, 1);
    rows[1] = ins(1, 9, 0, 4, 1, 0);
    rows[1].pc = 1;
    rows[2] = ins(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(rows[i]);
      vectors++;
      if (act_vec() !== model_expect()) begin
        miscompares++;
        $display("FAIL branch row %0d: got %h expected %h", i, act_vec(), model_expect());
      end
      if (i == 1) begin
        vectors++;
        if ({flush_D, flush_E, stall_F, stall_cnt} !== {3'b110, 4'd1}) begin
          miscompares++;
          $display("FAIL branch_wins: got %b%b%b/%0d expected 110/1", flush_D, flush_E, stall_F, stall_cnt);
        end
      end
      tick();
    end
  endtask

  task automatic test_mem_wait();
    stim_t rows[7];
    rows[0] = ins(1, 0, 0, 10, 1, 0);
    rows[1] = ins(1, 10, 0, 11, 1, 0);
    for (int i = 2; i < 6; i++) begin
      rows[i] = ins(1, 11, 10, 12, 1, 0);
      rows[i].req = 1;
      rows[i].rdy = (i == 5);
    end
    rows[6] = ins(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      drive(rows[i]);
      vectors++;
      if (act_vec() !== model_expect()) begin
        miscompares++;
        $display("FAIL mem_wait row %0d: got %h expected %h", i, act_vec(), model_expect());
      end
      if (i >= 2 && i <= 5) begin
        vectors++;
        if ({stall_F, stall_D, stall_E, stall_M, flush_W, forwardA_E} !==
            {{5{i != 5}}, 2'b10}) begin
          miscompares++;
          $display("FAIL mem_wait_ctl row %0d: got %b%b%b%b%b/%b", i, stall_F, stall_D,
                   stall_E, stall_M, flush_W, forwardA_E);
        end
      end
      tick();
    end
  endtask

  task automatic test_timeout();
    stim_t rows[10];
    for (int i = 0; i < 10; i++) begin
      rows[i] = ins(0, 0, 0, 0, 0, 0);
      rows[i].req = (i < 6) || (i == 9);
      rows[i].rdy = (i >= 6);
    end
    rows[8].rst = 1;
    for (int i = 0; i < 10; i++) begin
      drive(rows[i]);
      vectors++;
      if (act_vec() !== model_expect()) begin
        miscompares++;
        $display("FAIL timeout row %0d: got %h expected %h", i, act_vec(), model_expect());
      end
      vectors++;
      if (i < 5 && {stall_F, mem_error} !== 2'b10) begin
        miscompares++;
        $display("FAIL timeout_pre row %0d: got %b%b expected 10", i, stall_F, mem_error);
      end else if (i >= 5 && i <= 7 && {stall_F, stall_M, mem_error} !== 3'b111) begin
        miscompares++;
        $display("FAIL timeout_err row %0d: got %b%b%b expected 111", i, stall_F, stall_M, mem_error);
      end else if (i == 9 && {stall_F, mem_error} !== 2'b00) begin
        miscompares++;
        $display("FAIL timeout_reset: got %b%b expected 00", stall_F, mem_error);
      end
      tick();
    end
  endtask

  task automatic test_saturation();
    for (int n = 0; n < 20; n++) begin
      for (int k = 0; k < 3; k++) begin
        drive(k == 0 ? ins(1, 0, 0, 7, 1, 1) : ins(1, 7, 2, 3, 1, 0));
        vectors++;
        if (act_vec() !== model_expect()) begin
          miscompares++;
          $display("FAIL sat iter %0d.%0d: got %h expected %h", n, k, act_vec(), model_expect());
        end
        tick();
      end
    end
    drive(ins(0, 0, 0, 0, 0, 0));
    vectors++;
    if (stall_cnt !== 4'hF) begin
      miscompares++;
      $display("FAIL sat_final: got %0d expected 15", stall_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    stim_t s;
    for (int i = 0; i < 400; i++) begin
      s = ins(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
              int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      s.rst = ($urandom_range(0, 49) == 0);
      s.pc  = ($urandom_range(0, 7) == 0);
      s.req = 1'($urandom_range(0, 1));
      s.rdy = ($urandom_range(0, 3) != 0);
      drive(s);
      vectors++;
      if (act_vec() !== model_expect()) begin
        miscompares++;
        $display("FAIL random cycle %0d: got %h expected %h", i, act_vec(), model_expect());
      end
      tick();
    end
  endtask

  initial begin
    zi = '{default: 0};
    pe = zi; pm = zi; pw = zi;
    drive(ins(0, 0, 0, 0, 0, 0));
    test_reset();
    test_forwarding();
    test_load_use();
    test_branch_over_load_use();
    test_mem_wait();
    test_timeout();
    test_saturation();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
